plru_set_array: RTL and testbench



---
 rtl/plru_set_array_pkg.sv | 62 ++++++
 rtl/plru_set_array_if.sv | 31 +++
 rtl/plru_set_array_tree_logic.sv | 25 ++
 rtl/plru_set_array.sv | 117 +++++++++++
 tb/tb_plru_set_array.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/plru_set_array_pkg.sv
// Shared types and width-generic tree helpers for the multi-set pseudo-LRU unit.
// Trees up to 2**MAX_WAY_W ways are handled; callers cast results down to their own width.
package plru_pkg;

  localparam int MAX_WAY_W = 8;
  localparam int MAX_NODES = (1 << MAX_WAY_W) - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } flush_state_e;

  typedef logic [MAX_NODES-1:0] plru_tree_t;
  typedef logic [MAX_WAY_W-1:0] plru_way_t;

  function automatic int plru_set_w(input int sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  // Follow the LRU pointers from the root; the way index is accumulated MSB first.
  function automatic plru_way_t plru_victim(input plru_tree_t tree, input int ways);
    plru_way_t             victim;
    logic [MAX_WAY_W-1:0]  n;
    logic                  b;
    int                    way_w;
    way_w  = $clog2(ways);
    victim = '0;
    n      = '0;
    for (int lvl = 0; lvl < MAX_WAY_W; lvl++) begin
      if (lvl < way_w) begin
        b      = ~tree[n];
        victim = {victim[MAX_WAY_W-2:0], b};
        n      = (n << 1) + MAX_WAY_W'(1) + MAX_WAY_W'(b);
      end
    end
    return victim;
  endfunction

  // Point every node on the touched way's path away from it; off-path nodes keep their value.
  function automatic plru_tree_t plru_update(input plru_tree_t tree, input plru_way_t way,
                                             input int ways);
    plru_tree_t            t;
    plru_way_t             w;
    logic [MAX_WAY_W-1:0]  n;
    logic                  b;
    int                    way_w;
    way_w = $clog2(ways);
    t     = tree;
    w     = way << (MAX_WAY_W - way_w);
    n     = '0;
    for (int lvl = 0; lvl < MAX_WAY_W; lvl++) begin
      if (lvl < way_w) begin
        b    = w[MAX_WAY_W-1];
        t[n] = b;
        w    = w << 1;
        n    = (n << 1) + MAX_WAY_W'(1) + MAX_WAY_W'(b);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/plru_set_array_if.sv
// Lookup / touch / flush bus between the cache controller (master) and the PLRU array (slave).
interface plru_set_array_if
  import plru_pkg::*;
#(
  parameter int WAYS = 8,
  parameter int SETS = 32
) ();

  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = plru_set_w(SETS);

  logic [SET_W-1:0] lkp_set;
  logic [WAYS-1:0]  valid_mask;
  logic [WAY_W-1:0] victim_way;
  logic             touch;
  logic [SET_W-1:0] touch_set;
  logic [WAY_W-1:0] touch_way;
  logic             flush;
  logic             busy;

  modport master (
    output lkp_set, valid_mask, touch, touch_set, touch_way, flush,
    input  victim_way, busy
  );

  modport slave (
    input  lkp_set, valid_mask, touch, touch_set, touch_way, flush,
    output victim_way, busy
  );

endinterface

// File: rtl/plru_set_array_tree_logic.sv
// Combinational PLRU tree step: victim of the incoming tree and the tree after touching i_way.
module plru_tree_logic
  import plru_pkg::*;
#(
  parameter int WAYS = 8
) (
  input  logic [WAYS-2:0]         i_tree,
  input  logic [$clog2(WAYS)-1:0] i_way,
  output logic [WAYS-2:0]         o_tree,
  output logic [$clog2(WAYS)-1:0] o_victim
);

  localparam int WAY_W = $clog2(WAYS);
  localparam int NODES = WAYS - 1;

  plru_tree_t w_tree_ext;
  plru_way_t  w_way_ext;

  assign w_tree_ext = MAX_NODES'(i_tree);
  assign w_way_ext  = MAX_WAY_W'(i_way);

  assign o_tree   = NODES'(plru_update(w_tree_ext, w_way_ext, WAYS));
  assign o_victim = WAY_W'(plru_victim(w_tree_ext, WAYS));

endmodule

// File: rtl/plru_set_array.sv
// Multi-set tree pseudo-LRU replacement unit with internal touch update and flush sweep.
// Optional macro PLRU_INVALID_FIRST_EN: victim prefers the lowest invalid way from valid_mask.
module plru_set_array
  import plru_pkg::*;
#(
  parameter int WAYS = 8,
  parameter int SETS = 32
) (
  input logic             clk,
  input logic             rst,
  plru_set_array_if.slave bus
);

  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = plru_set_w(SETS);
  localparam int NODES = WAYS - 1;

  logic [NODES-1:0] r_tree_mem [SETS];
  flush_state_e     r_state;
  logic [SET_W-1:0] r_cnt;
  logic             r_busy;

  logic [NODES-1:0] w_lkp_tree;
  logic [NODES-1:0] w_touch_tree_old;
  logic [NODES-1:0] w_touch_tree_new;
  logic [WAY_W-1:0] w_tree_victim;
  logic [WAY_W-1:0] w_victim;
  logic [NODES-1:0] w_lkp_unused_tree;
  logic [WAY_W-1:0] w_touch_unused_victim;

  // Lookup reads the stored tree directly, so a same-cycle touch is not forwarded.
  assign w_lkp_tree       = r_tree_mem[bus.lkp_set];
  assign w_touch_tree_old = r_tree_mem[bus.touch_set];

  plru_tree_logic #(.WAYS(WAYS)) u_lkp_logic (
    .i_tree   (w_lkp_tree),
    .i_way    (bus.touch_way),
    .o_tree   (w_lkp_unused_tree),
    .o_victim (w_tree_victim)
  );

  plru_tree_logic #(.WAYS(WAYS)) u_touch_logic (
    .i_tree   (w_touch_tree_old),
    .i_way    (bus.touch_way),
    .o_tree   (w_touch_tree_new),
    .o_victim (w_touch_unused_victim)
  );

`ifdef PLRU_INVALID_FIRST_EN
  logic [WAYS:0]    w_all_valid_below;
  logic [WAYS-1:0]  w_first_hot;
  logic [WAY_W-1:0] w_first_inv;

  assign w_all_valid_below[0] = 1'b1;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_inv
    assign w_all_valid_below[gi+1] = w_all_valid_below[gi] & bus.valid_mask[gi];
    assign w_first_hot[gi]         = w_all_valid_below[gi] & ~bus.valid_mask[gi];
  end

  always_comb begin
    w_first_inv = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (w_first_hot[i]) begin
        w_first_inv = w_first_inv | WAY_W'(i);
      end
    end
  end

  assign w_victim = w_all_valid_below[WAYS] ? w_tree_victim : w_first_inv;
`else
  logic w_valid_mask_unused;

  assign w_valid_mask_unused = ^bus.valid_mask;
  assign w_victim            = w_tree_victim;
`endif

  assign bus.victim_way = w_victim;
  assign bus.busy       = r_busy;

  // Flush sweep FSM and the single tree write port share one block; the sweep owns the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_tree_mem[s] <= '1;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.flush) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else if (bus.touch) begin
            r_tree_mem[bus.touch_set] <= w_touch_tree_new;
          end
        end
        SWEEP: begin
          r_tree_mem[r_cnt] <= '1;
          r_cnt             <= r_cnt + SET_W'(1);
          if (r_cnt == SET_W'(SETS - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plru_set_array.sv
// Scoreboard bench for plru_set_array: stimulus queues expected values, a negedge monitor checks them.
module tb_plru_set_array;

  localparam int WAYS = 8;
  localparam int SETS = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  plru_set_array_if #(.WAYS(WAYS), .SETS(SETS)) bus ();

  plru_set_array #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      name;
    bit         is_busy;
    logic [7:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: every queued expectation belongs to the current cycle's outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t       e;
      logic [7:0] act;
      e   = exp_q.pop_front();
      act = e.is_busy ? {7'd0, bus.busy} : {5'd0, bus.victim_way};
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("[%0t] FAIL %s: got %0d, expected %0d", $time, e.name, act, e.exp);
      end else begin
        $display("[%0t] ok   %s: %0d", $time, e.name, act);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_victim(input string name, input int exp);
    exp_t e;
    e = '{name, 1'b0, 8'(exp)};
    exp_q.push_back(e);
  endtask

  task automatic chk_busy(input string name, input bit exp);
    exp_t e;
    e = '{name, 1'b1, {7'd0, exp}};
    exp_q.push_back(e);
  endtask

  int ways7[4] = '{2, 5, 0, 6};
  int exp7[4]  = '{4, 0, 6, 3};

  initial begin
    rst            = 1'b1;
    bus.lkp_set    = '0;
    bus.valid_mask = 8'hFF;
    bus.touch      = 1'b0;
    bus.touch_set  = '0;
    bus.touch_way  = '0;
    bus.flush      = 1'b0;
    tick();
    rst = 1'b0;

    // Reset state of every set
    for (int s = 0; s < SETS; s++) begin
      bus.lkp_set = 5'(s);
      chk_victim($sformatf("reset_victim_set%0d", s), 0);
      if (s == 0) chk_busy("reset_busy", 1'b0);
      tick();
    end

    // Touch all ways of set 5 in order, then way 0 again
    bus.touch     = 1'b1;
    bus.touch_set = 5'd5;
    for (int w = 0; w < WAYS; w++) begin
      bus.touch_way = 3'(w);
      tick();
    end
    bus.touch   = 1'b0;
    bus.lkp_set = 5'd5;
    chk_victim("set5_after_0to7", 0);
    tick();
    bus.touch     = 1'b1;
    bus.touch_way = 3'd0;
    tick();
    bus.touch = 1'b0;
    chk_victim("set5_after_touch0", 4);
    tick();

    // Read-before-write on the same set, and isolation from a neighbour
    bus.lkp_set   = 5'd3;
    bus.touch     = 1'b1;
    bus.touch_set = 5'd3;
    bus.touch_way = 3'd0;
    chk_victim("set3_same_cycle_old", 0);
    tick();
    bus.touch = 1'b0;
    chk_victim("set3_next_cycle", 4);
    tick();
    bus.lkp_set = 5'd4;
    chk_victim("set4_isolated", 0);
    tick();

    // Mixed touch pattern on set 7
    for (int i = 0; i < 4; i++) begin
      bus.touch     = 1'b1;
      bus.touch_set = 5'd7;
      bus.touch_way = 3'(ways7[i]);
      tick();
      bus.touch   = 1'b0;
      bus.lkp_set = 5'd7;
      chk_victim($sformatf("set7_after_way%0d", ways7[i]), exp7[i]);
      tick();
    end

    // Dirty every set, then flush with a stray flush and a stray touch during the sweep
    bus.touch     = 1'b1;
    bus.touch_way = 3'd0;
    for (int s = 0; s < SETS; s++) begin
      bus.touch_set = 5'(s);
      tick();
    end
    bus.touch   = 1'b0;
    bus.lkp_set = 5'd10;
    chk_victim("set10_dirty", 4);
    bus.flush = 1'b1;
    tick();
    for (int c = 1; c <= SETS + 1; c++) begin
      chk_busy($sformatf("flush_busy_cycle%0d", c), c <= SETS);
      bus.flush     = (c == 5);
      bus.touch     = (c == 20);
      bus.touch_set = 5'd2;
      bus.touch_way = 3'd0;
      tick();
    end
    bus.flush = 1'b0;
    bus.touch = 1'b0;
    for (int s = 0; s < SETS; s++) begin
      bus.lkp_set = 5'(s);
      chk_victim($sformatf("post_flush_set%0d", s), 0);
      tick();
    end

    // Reset during the tenth sweep cycle
    bus.touch     = 1'b1;
    bus.touch_way = 3'd0;
    bus.touch_set = 5'd0;  tick();
    bus.touch_set = 5'd15; tick();
    bus.touch_set = 5'd31; tick();
    bus.touch   = 1'b0;
    bus.lkp_set = 5'd31;
    chk_victim("set31_dirty_pre_flush", 4);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk_busy($sformatf("midflush_busy_cycle%0d", c), 1'b1);
      rst = (c == 10);
      tick();
    end
    rst = 1'b0;
    chk_busy("busy_after_rst", 1'b0);
    bus.lkp_set = 5'd31;
    chk_victim("set31_after_rst", 0);
    tick();
    bus.lkp_set = 5'd15;
    chk_victim("set15_after_rst", 0);
    chk_busy("busy_stays_low", 1'b0);
    tick();

    // valid_mask handling
    bus.touch     = 1'b1;
    bus.touch_set = 5'd9;
    bus.touch_way = 3'd0;
    tick();
    bus.touch      = 1'b0;
    bus.lkp_set    = 5'd9;
    bus.valid_mask = 8'b1111_0011;
`ifdef PLRU_INVALID_FIRST_EN
    chk_victim("mask_f3", 2);
`else
    chk_victim("mask_f3", 4);
`endif
    tick();
    bus.valid_mask = 8'b0111_1111;
`ifdef PLRU_INVALID_FIRST_EN
    chk_victim("mask_7f", 7);
`else
    chk_victim("mask_7f", 4);
`endif
    tick();
    bus.valid_mask = 8'hFF;
    chk_victim("mask_ff_tree", 4);
    tick();

    tick();
    tick();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
